// File: rtl/cdb_arbiter_if.sv
// Bus bundle for the common data bus arbiter.
// The master side drives FU results, flush and rob_head.
// The slave side is the arbiter: it returns fu_ready, the CDB broadcast and pending.
interface cdb_arbiter_if #(
  parameter int FU_COUNT = 8,
  parameter int VAL_W    = 8,
  parameter int ROBID_W  = 4
);
  localparam int PEND_W = $clog2(FU_COUNT + 1);

  logic [FU_COUNT-1:0]               fu_valid;
  logic [FU_COUNT-1:0][VAL_W-1:0]    fu_val;
  logic [FU_COUNT-1:0][ROBID_W-1:0]  fu_robid;
  logic [FU_COUNT-1:0]               fu_ready;
  logic                              flush;
  logic [ROBID_W-1:0]                rob_head;
  logic [VAL_W-1:0]                  cdbval;
  logic [ROBID_W-1:0]                cdbid;
  logic                              cdbtransmit;
  logic [PEND_W-1:0]                 pending;

  modport master (
    output fu_valid, fu_val, fu_robid, flush, rob_head,
    input  fu_ready, cdbval, cdbid, cdbtransmit, pending
  );

  modport slave (
    input  fu_valid, fu_val, fu_robid, flush, rob_head,
    output fu_ready, cdbval, cdbid, cdbtransmit, pending
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered CDB broadcast among FU_COUNT functional units.
// Each FU has a one-entry holding buffer (EMPTY/FULL) with a valid/ready handshake.
// By default a round-robin pointer chooses the next full buffer.
// Define CDB_AGE_PRIORITY_EN to grant instead the buffer whose ROB tag is oldest
// relative to rob_head, with ties going to the lowest index.
module cdb_arbiter #(
  parameter int FU_COUNT = 8,
  parameter int VAL_W    = 8,
  parameter int ROBID_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W  = $clog2(FU_COUNT);
  localparam int PEND_W = $clog2(FU_COUNT + 1);

  logic [FU_COUNT-1:0] full_reg, full_next;
  logic [FU_COUNT-1:0] grant, accept;
  logic [VAL_W-1:0]    val_reg   [FU_COUNT];
  logic [ROBID_W-1:0]  robid_reg [FU_COUNT];
  logic [PTR_W-1:0]    rr_ptr_reg, grant_idx;
  logic                grant_any;
  logic [VAL_W-1:0]    cdbval_reg;
  logic [ROBID_W-1:0]  cdbid_reg;
  logic                cdbtransmit_reg;
  logic [PEND_W-1:0]   pending_next;

  // Buffer state register: all buffers start empty.
  always_ff @(posedge clk) begin
    if (rst) full_reg <= '0;
    else     full_reg <= full_next;
  end

  // Buffer next state: a flush empties everything; otherwise fill on accept,
  // drain on grant, and a same-cycle refill keeps the buffer full.
  always_comb begin
    full_next = accept | (full_reg & ~grant);
    if (bus.flush) full_next = '0;
  end

`ifdef CDB_AGE_PRIORITY_EN
  // Grant selection: the smallest distance from rob_head is the oldest result.
  always_comb begin
    logic [ROBID_W-1:0] age;
    logic [ROBID_W-1:0] best_age;
    grant_any = 1'b0;
    grant_idx = '0;
    age       = '0;
    best_age  = '1;
    for (int i = 0; i < FU_COUNT; i++) begin
      age = robid_reg[i] - bus.rob_head;
      if (full_reg[i] && (!grant_any || age < best_age)) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(i);
        best_age  = age;
      end
    end
  end
`else
  logic unused_rob_head;
  assign unused_rob_head = ^bus.rob_head;

  // Grant selection: the first full buffer at or after rr_ptr, wrapping around.
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < FU_COUNT; k++) begin
      idx = PTR_W'((int'(rr_ptr_reg) + k) % FU_COUNT);
      if (!grant_any && full_reg[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end
`endif

  // Handshake outputs: one-hot grant; a granted buffer can be refilled in the same cycle.
  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
    bus.fu_ready = ~full_reg | grant;
    accept       = bus.fu_valid & bus.fu_ready;
  end

  // Payload capture per buffer; contents only matter while the buffer is full.
  generate
    for (genvar gi = 0; gi < FU_COUNT; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (accept[gi]) begin
          val_reg[gi]   <= bus.fu_val[gi];
          robid_reg[gi] <= bus.fu_robid[gi];
        end
      end
    end
  endgenerate

  // Registered CDB broadcast and round-robin pointer; idle cycles drive zeros
  // so OR-combined downstream buses stay clean. A flush suppresses the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdbval_reg      <= '0;
      cdbid_reg       <= '0;
      cdbtransmit_reg <= 1'b0;
      rr_ptr_reg      <= '0;
    end else if (bus.flush || !grant_any) begin
      cdbval_reg      <= '0;
      cdbid_reg       <= '0;
      cdbtransmit_reg <= 1'b0;
    end else begin
      cdbval_reg      <= val_reg[grant_idx];
      cdbid_reg       <= robid_reg[grant_idx];
      cdbtransmit_reg <= 1'b1;
      rr_ptr_reg      <= (grant_idx == PTR_W'(FU_COUNT - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Occupancy count taken from the buffer state registers.
  always_comb begin
    pending_next = '0;
    for (int i = 0; i < FU_COUNT; i++)
      pending_next = pending_next + {{(PEND_W-1){1'b0}}, full_reg[i]};
  end

  assign bus.cdbval      = cdbval_reg;
  assign bus.cdbid       = cdbid_reg;
  assign bus.cdbtransmit = cdbtransmit_reg;
  assign bus.pending     = pending_next;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts
// (hand-ordered) into a queue and a negedge monitor pops and compares them.
module tb_cdb_arbiter;
  localparam int N  = 8;
  localparam int VW = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.FU_COUNT(N), .VAL_W(VW), .ROBID_W(IW)) bus ();

  cdb_arbiter #(.FU_COUNT(N), .VAL_W(VW), .ROBID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [VW+IW-1:0] exp_q[$];
  logic [VW+IW-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", name, act, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fu_valid = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic drive_one(input int i, input logic [VW-1:0] v, input logic [IW-1:0] id);
    bus.fu_valid[i] = 1'b1;
    bus.fu_val[i]   = v;
    bus.fu_robid[i] = id;
  endtask

  task automatic expect_bcast(input logic [VW-1:0] v, input logic [IW-1:0] id);
    exp_q.push_back({v, id});
  endtask

  // Monitor: every broadcast must match the head of the scoreboard;
  // idle cycles must show all-zero CDB outputs.
  always @(negedge clk) begin
    if (bus.cdbtransmit === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_bcast: got val=%0h id=%0h, expected none (t=%0t)",
                 bus.cdbval, bus.cdbid, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bcast_val", 32'(bus.cdbval), 32'(mon_e[VW+IW-1:IW]));
        chk("bcast_id",  32'(bus.cdbid),  32'(mon_e[IW-1:0]));
      end
    end else begin
      n_vec++;
      if ({bus.cdbtransmit, bus.cdbval, bus.cdbid} !== '0) begin
        n_err++;
        $display("FAIL idle_zero: got tx=%b val=%0h id=%0h, expected 0 (t=%0t)",
                 bus.cdbtransmit, bus.cdbval, bus.cdbid, $time);
      end
    end
  end

  initial begin
    bus.fu_valid = '0;
    bus.fu_val   = '0;
    bus.fu_robid = '0;
    bus.flush    = 1'b0;
    bus.rob_head = '0;
    rst = 1'b1;
    step();
    step();
    chk("rst_tx",      32'(bus.cdbtransmit), 0);
    chk("rst_val",     32'(bus.cdbval), 0);
    chk("rst_id",      32'(bus.cdbid), 0);
    chk("rst_ready",   32'(bus.fu_ready), 32'hFF);
    chk("rst_pending", 32'(bus.pending), 0);
    rst = 1'b0;
    step();

    // Single result, two-cycle latency, exactly one broadcast cycle.
    drive_one(3, 8'h5A, 4'd7);
    expect_bcast(8'h5A, 4'd7);
    step();
    clear_inputs();
    chk("t1_tx_e0",  32'(bus.cdbtransmit), 0);
    chk("t1_pend_e0", 32'(bus.pending), 1);
    step();
    chk("t1_tx_e1",  32'(bus.cdbtransmit), 1);
    chk("t1_pend_e1", 32'(bus.pending), 0);
    step();
    chk("t1_tx_e2",  32'(bus.cdbtransmit), 0);

    // Re-reset so rr_ptr is 0, then full contention.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      drive_one(i, 8'(8'h10 + i), 4'(i));
      expect_bcast(8'(8'h10 + i), 4'(i));
    end
    step();
    clear_inputs();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t2_ready_%0d", k), 32'(bus.fu_ready), ((1 << (k + 1)) - 1) & 32'hFF);
      chk($sformatf("t2_pend_%0d", k),  32'(bus.pending), N - k);
      step();
    end
    chk("t2_pend_end", 32'(bus.pending), 0);
    step();

    // Wrap fairness: grant FU6 first (rr_ptr -> 7), then FU2+FU7 give FU7, FU2.
    drive_one(6, 8'h66, 4'd6);
    expect_bcast(8'h66, 4'd6);
    step();
    clear_inputs();
    step();
    step();
    drive_one(2, 8'h22, 4'd2);
    drive_one(7, 8'h77, 4'd7);
    expect_bcast(8'h77, 4'd7);
    expect_bcast(8'h22, 4'd2);
    step();
    clear_inputs();
    step();
    step();
    step();

    // Back-to-back from FU1: ready stays high, broadcasts on consecutive cycles.
    for (int v = 1; v <= 4; v++) begin
      if (v >= 3) chk($sformatf("t4_tx_%0d", v), 32'(bus.cdbtransmit), 1);
      chk($sformatf("t4_ready_%0d", v), 32'(bus.fu_ready[1]), 1);
      drive_one(1, 8'(v), 4'(8 + v));
      expect_bcast(8'(v), 4'(8 + v));
      step();
    end
    clear_inputs();
    chk("t4_tx_e4", 32'(bus.cdbtransmit), 1);
    step();
    chk("t4_tx_e5", 32'(bus.cdbtransmit), 1);
    step();
    chk("t4_tx_e6", 32'(bus.cdbtransmit), 0);
    step();

    // Flush with three buffers full; FU2 valid during flush is dropped.
    drive_one(0, 8'hA0, 4'd1);
    drive_one(4, 8'hA4, 4'd2);
    drive_one(5, 8'hA5, 4'd3);
    step();
    clear_inputs();
    chk("t5_pend_pre", 32'(bus.pending), 3);
    bus.flush = 1'b1;
    drive_one(2, 8'hB2, 4'd4);
    step();
    clear_inputs();
    chk("t5_tx",    32'(bus.cdbtransmit), 0);
    chk("t5_pend",  32'(bus.pending), 0);
    chk("t5_ready", 32'(bus.fu_ready), 32'hFF);
    step();
    step();
    chk("t5_pend_late", 32'(bus.pending), 0);

    // Reset mid-burst: rr_ptr is 2 so FU4 goes first, then rst drops the rest.
    drive_one(0, 8'hC0, 4'd5);
    drive_one(4, 8'hC4, 4'd6);
    drive_one(5, 8'hC5, 4'd7);
    expect_bcast(8'hC4, 4'd6);
    step();
    clear_inputs();
    step();
    rst = 1'b1;
    step();
    chk("t6_tx",    32'(bus.cdbtransmit), 0);
    chk("t6_val",   32'(bus.cdbval), 0);
    chk("t6_id",    32'(bus.cdbid), 0);
    chk("t6_pend",  32'(bus.pending), 0);
    chk("t6_ready", 32'(bus.fu_ready), 32'hFF);
    rst = 1'b0;
    step();
    step();
    chk("t6_pend_late", 32'(bus.pending), 0);

`ifdef CDB_AGE_PRIORITY_EN
    // Age priority: rob_head=14, robid 15 is older than robid 1.
    bus.rob_head = 4'd14;
    drive_one(0, 8'hE0, 4'd1);
    drive_one(5, 8'hE5, 4'd15);
    expect_bcast(8'hE5, 4'd15);
    expect_bcast(8'hE0, 4'd1);
    step();
    clear_inputs();
    step();
    step();
    step();
`endif

    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (cdbval/cdbid/cdbtransmit) among FU_COUNT functional units completing results.
- Each FU owns a one-entry holding buffer with a valid/ready handshake. A round-robin scheduler picks one buffered result per cycle and drives a registered CDB broadcast.
- The broadcast is consumed by the reservation stations, the ROB and the PRF.

Parameters:
- FU_COUNT, 8, number of functional units / requesters (>=2).
- VAL_W, 8, result value width.
- ROBID_W, 4, ROB tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fu_valid  in  FU_COUNT  per-FU result valid.
- fu_val  in  FU_COUNT x VAL_W  per-FU result value.
- fu_robid  in  FU_COUNT x ROBID_W  per-FU result ROB tag.
- fu_ready  out  FU_COUNT  per-FU buffer can accept this cycle.
- flush  in  1  discard all buffered results (mispredict).
- rob_head  in  ROBID_W  current ROB head tag; used only with the optional feature.
- cdbval  out  VAL_W  broadcast value.
- cdbid  out  ROBID_W  broadcast ROB tag.
- cdbtransmit  out  1  broadcast valid, one cycle per result.
- pending  out  $clog2(FU_COUNT+1)  count of occupied buffers.

Behaviour:
- Reset: all buffers empty; rr_ptr=0; cdbval=0, cdbid=0, cdbtransmit=0; fu_ready all 1; pending=0.
- Buffer i states are EMPTY and FULL.
  - EMPTY -> FULL on fu_valid[i]&fu_ready[i].
  - FULL -> EMPTY when granted, unless it is refilled in the same cycle.
- fu_ready[i] = ~full[i] | grant[i]. This is combinational and allows back-to-back results from one FU at one per cycle.
- Grant logic (combinational over FULL buffers only; incoming results are not eligible the same cycle):
  - Pick the first full buffer at index >= rr_ptr, wrapping modulo FU_COUNT.
  - At most one grant per cycle.
- On a grant to index g, at the clock edge:
  - cdbval/cdbid <= buffer g contents; cdbtransmit <= 1.
  - rr_ptr <= (g+1) mod FU_COUNT.
- No grant: cdbtransmit <= 0, and cdbval/cdbid <= 0 so downstream OR-buses see zeros. rr_ptr holds.
- Latency: a result accepted at edge E is broadcast (cdbtransmit=1) in the cycle after edge E+1 at the earliest. It is 2 cycles from its valid cycle when uncontended.
- Fairness: a FULL buffer is granted within FU_COUNT cycles.
- Flush:
  - All buffers -> EMPTY at the edge; fu_valid in the flush cycle is dropped.
  - cdbtransmit <= 0 for the next cycle.
  - rr_ptr is kept.
- rst has priority over flush; rst mid-operation drops all buffered results.
- pending = popcount(full), a registered view.
- Stalls are never internal: backpressure is expressed only by fu_ready.

Optional Feature:
- CDB_AGE_PRIORITY_EN
- Defined: the grant goes to the full buffer whose robid is oldest, i.e. the minimum of (robid - rob_head) mod 2^ROBID_W. Ties are broken by the lowest index. rr_ptr is still updated but has no effect.
- Undefined: pure round-robin as above; rob_head is ignored.

Test Plan:
- Single result: fu_valid[3]=1, val=0x5A, robid=7 for one cycle -> two cycles later cdbtransmit=1, cdbval=0x5A, cdbid=7 for exactly one cycle; pending returns to 0.
- Contention: FU0..FU7 all valid in the same cycle, vals 0x10..0x17, rr_ptr=0 -> 8 consecutive broadcasts in order 0x10..0x17; fu_ready deasserted on FU i until its grant cycle.
- Wrap fairness: after a grant to FU6, assert FU2 and FU7 -> FU7 broadcast first, then FU2.
- Back-to-back same FU: FU1 valid for 4 cycles, vals 1,2,3,4, no other traffic -> fu_ready[1] stays 1; broadcasts 1,2,3,4 on consecutive cycles.
- Flush with 3 buffers full -> the next cycle has cdbtransmit=0, pending=0 after the edge, no stale values ever broadcast; rst mid-burst -> same, and all outputs 0.
- Age mode (CDB_AGE_PRIORITY_EN): rob_head=14, FU0 robid=1, FU5 robid=15 full together -> FU5 (robid 15) broadcast first, then FU0.
